// File: rtl/div_hilo_unit_pkg.sv
// Shared types and constants for the HI/LO divide unit.
// Holds the divider FSM encoding and the divide-by-zero LO fill bit.
package div_hilo_unit_pkg;

    typedef enum logic [1:0] {
        DIVS_IDLE  = 2'd0,
        DIVS_ITER  = 2'd1,
        DIVS_FIXUP = 2'd2
    } div_state_e;

    // LO is filled with this bit (all ones) on a zero divisor.
    localparam logic DIV_ZERO_LO_BIT = 1'b1;

endpackage

// File: rtl/div_hilo_unit_step.sv
// One restoring division step: shift {rem, quot} left, trial-subtract.
// Ports: rem/quot in (current), dmag (|divisor|), rem_next/quot_next out.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH:0]   dmag,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted   = {rem, quot[WIDTH-1]};
        trial     = shifted - {1'b0, dmag};
        rem_next  = shifted[WIDTH:0];
        quot_next = {quot[WIDTH-2:0], 1'b0};
        // Borrow bit clear means the trial remainder is non-negative.
        if (!trial[WIDTH+1]) begin
            rem_next     = trial[WIDTH:0];
            quot_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_hilo_unit.sv
// Multi-cycle signed divider owning HI (remainder) and LO (quotient).
// Ports: clk, reset, div_start, dividend, divisor, decode hazard inputs
// (is_mf_hi_d, is_mf_lo_d, has_div_d); outputs stall_d, busy, hi, lo.
module div_hilo_unit
    import div_hilo_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_mf_hi_d,
    input  logic             is_mf_lo_d,
    input  logic             has_div_d,
    output logic             stall_d,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e       state;
    div_state_e       state_next;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH:0]   dmag;
    logic [WIDTH-1:0] dvd;
    logic             sign_q;
    logic             sign_r;
    logic             dzero;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    logic             start_ok;
    logic             in_zero;

    assign start_ok = div_start && (state == DIVS_IDLE);
    assign in_zero  = (divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem),
        .quot      (quot),
        .dmag      (dmag),
        .rem_next  (rem_next),
        .quot_next (quot_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DIVS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            DIVS_IDLE: begin
                if (start_ok) begin
                    state_next = (in_zero && ZERO_FAST) ? DIVS_FIXUP
                                                        : DIVS_ITER;
                end
            end
            DIVS_ITER: begin
                if (count == LAST) begin
                    state_next = DIVS_FIXUP;
                end
            end
            DIVS_FIXUP: state_next = DIVS_IDLE;
            default:    state_next = DIVS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rem    <= '0;
            quot   <= '0;
            dmag   <= '0;
            dvd    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dzero  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            unique case (state)
                DIVS_IDLE: begin
                    if (start_ok) begin
                        // Unsigned magnitudes; -2^(W-1) maps to 2^(W-1).
                        quot   <= dividend[WIDTH-1] ? -dividend : dividend;
                        dmag   <= {1'b0, divisor[WIDTH-1] ? -divisor
                                                          : divisor};
                        dvd    <= dividend;
                        sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r <= dividend[WIDTH-1];
                        dzero  <= in_zero;
                        rem    <= '0;
                        count  <= '0;
                    end
                end
                DIVS_ITER: begin
                    rem   <= rem_next;
                    quot  <= quot_next;
                    count <= count + 1'b1;
                end
                DIVS_FIXUP: begin
                    if (dzero) begin
                        lo <= {WIDTH{DIV_ZERO_LO_BIT}};
                        hi <= dvd;
                    end else begin
                        lo <= sign_q ? -quot : quot;
                        hi <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != DIVS_IDLE);
    assign stall_d = busy & (is_mf_hi_d | is_mf_lo_d | has_div_d);

endmodule

// File: tb/tb_div_hilo_unit.sv
// Self-checking bench for div_hilo_unit: vector table with scoreboard,
// plus stall and mid-divide reset sequences.
module tb_div_hilo_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         div_start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_mf_hi_d;
    logic         is_mf_lo_d;
    logic         has_div_d;
    logic         stall_d;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
        int           cycles;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } res_t;

    res_t sb[$];
    vec_t vecs[11];

    div_hilo_unit #(.WIDTH(W), .ZERO_FAST(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_start  (div_start),
        .dividend   (dividend),
        .divisor    (divisor),
        .is_mf_hi_d (is_mf_hi_d),
        .is_mf_lo_d (is_mf_lo_d),
        .has_div_d  (has_div_d),
        .stall_d    (stall_d),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop expected result when busy falls.
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (busy_prev && !busy && sb.size() > 0) begin
            res_t r;
            r = sb.pop_front();
            checks++;
            if (lo !== r.lo) begin
                errors++;
                $display("FAIL lo: got %h want %h", lo, r.lo);
            end
            checks++;
            if (hi !== r.hi) begin
                errors++;
                $display("FAIL hi: got %h want %h", hi, r.hi);
            end
        end
        busy_prev = busy;
    end

    // Protocol guard: a start while busy must never be issued.
    always @(posedge clk) begin
        if (div_start && busy && !reset) begin
            errors++;
            $display("FAIL protocol: div_start while busy");
        end
    end

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Count busy cycles after the start edge; bounded.
    task automatic count_busy(output int n, output bit stall_bad);
        n = 0;
        stall_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            if (is_mf_lo_d && !stall_d) stall_bad = 1'b1;
            n++;
            if (n > 200) break;
        end
    endtask

    initial begin
        int  n;
        bit  sbad;
        reset      = 1'b1;
        div_start  = 1'b1;
        dividend   = 32'd9;
        divisor    = 32'd3;
        is_mf_hi_d = 1'b1;
        is_mf_lo_d = 1'b0;
        has_div_d  = 1'b0;

        vecs[0]  = '{32'd7,        32'd2,        32'h3,        32'h1,        33};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        33};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        33};
        vecs[4]  = '{32'd5,        32'd0,        32'hFFFFFFFF, 32'h5,        1};
        vecs[5]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'hE,        32'hFFFFFFFE, 33};
        vecs[6]  = '{32'd0,        32'd5,        32'h0,        32'h0,        33};
        vecs[7]  = '{32'h7FFFFFFF, 32'h80000000, 32'h0,        32'h7FFFFFFF, 33};
        vecs[8]  = '{32'h80000000, 32'd1,        32'h80000000, 32'h0,        33};
        vecs[9]  = '{32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1};
        vecs[10] = '{32'h12345678, 32'd1000,     32'h4A90B,    32'h380,      33};

        // Reset wins over div_start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  {31'b0, busy},    32'h0);
        check("rst_stall", {31'b0, stall_d}, 32'h0);
        check("rst_hi",    hi, 32'h0);
        check("rst_lo",    lo, 32'h0);
        #1;
        reset      = 1'b0;
        div_start  = 1'b0;
        is_mf_hi_d = 1'b0;

        foreach (vecs[i]) begin
            sb.push_back('{vecs[i].exp_lo, vecs[i].exp_hi});
            start(vecs[i].a, vecs[i].b);
            count_busy(n, sbad);
            check($sformatf("busy_cyc[%0d]", i), n, vecs[i].cycles);
            @(negedge clk);
        end

        // 100 / 7 with MFLO in decode: stall through FIXUP.
        sb.push_back('{32'd14, 32'd2});
        start(32'd100, 32'd7);
        is_mf_lo_d = 1'b1;
        count_busy(n, sbad);
        check("stall_busy_cyc", n, 33);
        check("stall_held", {31'b0, sbad}, 32'h0);
        check("stall_release", {31'b0, stall_d}, 32'h0);
        check("stall_lo", lo, 32'd14);
        check("stall_hi", hi, 32'd2);

        // Same divide, reset at ITER cycle 10.
        @(negedge clk);
        start(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre_rst_stall", {31'b0, stall_d}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy",  {31'b0, busy},    32'h0);
        check("abort_stall", {31'b0, stall_d}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        is_mf_lo_d = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("abort_hold_lo", lo, 32'h0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
